// File: rtl/key_schedule.sv
// AES-128 round-key generator.
// key_expansion : combinational single-round AES-128 key expansion step.
// key_schedule  : iterates one key_expansion per clock and stores round keys 0..NR
//                 in a register file with a combinational round-indexed read port.

module key_expansion (
    input  logic [127:0] in_key,
    input  logic [31:0]  rcon,
    output logic [127:0] out_key
);

    // AES S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_word;
    logic [31:0] temp_word;
    logic [31:0] o0, o1, o2, o3;

    assign w0 = in_key[127:96];
    assign w1 = in_key[95:64];
    assign w2 = in_key[63:32];
    assign w3 = in_key[31:0];

    // RotWord, then SubWord, then Rcon injection into the top byte.
    assign rot_word  = {w3[23:0], w3[31:24]};
    assign temp_word = {sub_byte(rot_word[31:24]), sub_byte(rot_word[23:16]),
                        sub_byte(rot_word[15:8]),  sub_byte(rot_word[7:0])} ^ rcon;

    assign o0 = w0 ^ temp_word;
    assign o1 = o0 ^ w1;
    assign o2 = o1 ^ w2;
    assign o3 = o2 ^ w3;

    assign out_key = {o0, o1, o2, o3};

endmodule

module key_schedule #(
    parameter int NR = 10   // 1..10; Rcon is only defined for rounds 1..10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] cipher_key,
    input  logic [3:0]   round_sel,
    output logic [127:0] round_key,
    output logic         busy,
    output logic         keys_valid,
    output logic         done_pulse
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

    state_t       state_reg, state_next;
    logic [3:0]   round_reg, round_next;
    logic         busy_reg, busy_next;
    logic         valid_reg, valid_next;
    logic         done_reg, done_next;
    logic         load_key;
    logic         write_round;
    logic [NR:0]  slot_we;

    logic [127:0] slot_reg [0:NR];
    logic [127:0] prev_key;
    logic [127:0] exp_key;
    logic [31:0]  rcon;

    function automatic logic [7:0] rc_byte(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Select slot[round-1] as the expansion input; round 0 never expands.
    always_comb begin
        prev_key = '0;
        for (int i = 0; i < NR; i++) begin
            if (round_reg == 4'(i + 1)) begin
                prev_key = slot_reg[i];
            end
        end
    end

    assign rcon = {rc_byte(round_reg), 24'h0};

    key_expansion u_key_expansion (
        .in_key  (prev_key),
        .rcon    (rcon),
        .out_key (exp_key)
    );

    // Combinational read port; out-of-range indices read as zero.
    always_comb begin
        round_key = '0;
        for (int i = 0; i <= NR; i++) begin
            if (round_sel == 4'(i)) begin
                round_key = slot_reg[i];
            end
        end
    end

    // Next-state and control decode; start is only honoured outside EXPAND.
    always_comb begin
        state_next  = state_reg;
        round_next  = round_reg;
        busy_next   = busy_reg;
        valid_next  = valid_reg;
        done_next   = 1'b0;
        load_key    = 1'b0;
        write_round = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    load_key   = 1'b1;
                    round_next = 4'd1;
                    busy_next  = 1'b1;
                    valid_next = 1'b0;
                    state_next = EXPAND;
                end
            end
            EXPAND: begin
                write_round = 1'b1;
                if (round_reg == LAST_ROUND) begin
                    round_next = 4'd0;
                    busy_next  = 1'b0;
                    valid_next = 1'b1;
                    done_next  = 1'b1;
                    state_next = DONE;
                end else begin
                    round_next = round_reg + 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                round_next = 4'd0;
                busy_next  = 1'b0;
                valid_next = 1'b0;
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            round_reg <= 4'd0;
            busy_reg  <= 1'b0;
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            round_reg <= round_next;
            busy_reg  <= busy_next;
            valid_reg <= valid_next;
            done_reg  <= done_next;
        end
    end

    // Per-slot write enables: slot 0 takes the cipher key, slot r the round-r result.
    genvar gi;
    generate
        for (gi = 0; gi <= NR; gi++) begin : g_slot_we
            if (gi == 0) begin : g_key
                assign slot_we[gi] = load_key;
            end else begin : g_round
                assign slot_we[gi] = write_round && (round_reg == 4'(gi));
            end
        end
    endgenerate

    // Round-key register file; reset wipes every slot so no stale keys survive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= NR; i++) begin
                slot_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i <= NR; i++) begin
                if (slot_we[i]) begin
                    slot_reg[i] <= (i == 0) ? cipher_key : exp_key;
                end
            end
        end
    end

    assign busy       = busy_reg;
    assign keys_valid = valid_reg;
    assign done_pulse = done_reg;

endmodule

// File: tb/tb_key_schedule.sv
// Scoreboard bench for key_schedule: the stimulus process queues expected
// status flags and round-key reads; a monitor process checks them against the DUT.
`timescale 1ns/1ps

module tb_key_schedule;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] cipher_key = '0;
    logic [3:0]   round_sel = 4'd0;
    logic [127:0] round_key;
    logic         busy;
    logic         keys_valid;
    logic         done_pulse;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] ALT_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

    key_schedule #(.NR(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cipher_key (cipher_key),
        .round_sel  (round_sel),
        .round_key  (round_key),
        .busy       (busy),
        .keys_valid (keys_valid),
        .done_pulse (done_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [2:0] exp;      // {busy, keys_valid, done_pulse}
    } sts_t;

    typedef struct {
        string        name;
        logic [3:0]   sel;
        logic [127:0] exp;
        bit           anytime; // check without waiting for keys_valid
    } key_t;

    sts_t sts_q[$];
    key_t key_q[$];

    int checks = 0;
    int errors = 0;

    // Monitor: status entries at the next falling edge; key reads once keys_valid is up.
    initial begin
        sts_t s;
        key_t k;
        forever begin
            @(negedge clk);
            while (sts_q.size() > 0) begin
                s = sts_q.pop_front();
                checks++;
                if ({busy, keys_valid, done_pulse} !== s.exp) begin
                    errors++;
                    $display("FAIL %s: busy/valid/done got %b want %b",
                             s.name, {busy, keys_valid, done_pulse}, s.exp);
                end else begin
                    $display("ok   %s: busy/valid/done %b", s.name, s.exp);
                end
            end
            while (key_q.size() > 0 && (keys_valid === 1'b1 || key_q[0].anytime)) begin
                k = key_q.pop_front();
                round_sel = k.sel;
                #1;
                checks++;
                if (round_key !== k.exp) begin
                    errors++;
                    $display("FAIL %s: round_key[%0d] got %h want %h",
                             k.name, k.sel, round_key, k.exp);
                end else begin
                    $display("ok   %s: round_key[%0d] %h", k.name, k.sel, k.exp);
                end
            end
        end
    end

    task automatic push_sts(input string name, input logic b, input logic v, input logic d);
        sts_t s;
        s.name = name;
        s.exp  = {b, v, d};
        sts_q.push_back(s);
    endtask

    task automatic push_key(input string name, input logic [3:0] sel,
                            input logic [127:0] exp, input bit anytime);
        key_t k;
        k.name    = name;
        k.sel     = sel;
        k.exp     = exp;
        k.anytime = anytime;
        key_q.push_back(k);
    endtask

    task automatic push_fips_keys(input string tag);
        push_key({tag, "_r0"},  4'd0,  FIPS_KEY, 1'b0);
        push_key({tag, "_r1"},  4'd1,  FIPS_R1,  1'b0);
        push_key({tag, "_r2"},  4'd2,  FIPS_R2,  1'b0);
        push_key({tag, "_r10"}, 4'd10, FIPS_R10, 1'b0);
    endtask

    task automatic push_zero_keys(input string tag);
        push_key({tag, "_r0"},  4'd0,  128'h0,   1'b0);
        push_key({tag, "_r1"},  4'd1,  ZERO_R1,  1'b0);
        push_key({tag, "_r2"},  4'd2,  ZERO_R2,  1'b0);
        push_key({tag, "_r10"}, 4'd10, ZERO_R10, 1'b0);
    endtask

    // Called at posedge+2; issues start for one cycle, returns at E0+2.
    task automatic do_start(input logic [127:0] key);
        start      = 1'b1;
        cipher_key = key;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    // Expected flags from E0 through one cycle after keys_valid rises.
    // A non-zero inject cycle re-asserts start with ALT_KEY during EXPAND.
    task automatic track_latency(input string tag, input int inject);
        push_sts({tag, "_e0"}, 1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk);
            #2;
            start = 1'b0;
            push_sts($sformatf("%s_e%0d", tag, c), (c < 10), (c >= 10), (c == 10));
            if (c == inject) begin
                start      = 1'b1;
                cipher_key = ALT_KEY;
            end
        end
    endtask

    // Wait (bounded) until the monitor has consumed every queued expectation.
    task automatic wait_drain();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while ((sts_q.size() > 0 || key_q.size() > 0) && n < 200);
        #2;
        if (sts_q.size() > 0 || key_q.size() > 0) begin
            key_q.delete();
            push_sts("drain_timeout", 1'b0, 1'b1, 1'b0);
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        push_sts("reset_flags", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i <= 10; i++) push_key("reset_slot", 4'(i), 128'h0, 1'b1);
        wait_drain();
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // FIPS-197 key from IDLE
        do_start(FIPS_KEY);
        push_fips_keys("fips");
        track_latency("fips", 0);
        wait_drain();

        // Restart from DONE with the all-zero key
        do_start(128'h0);
        push_zero_keys("zero");
        track_latency("zero", 0);
        wait_drain();

        // start re-asserted during EXPAND must be ignored
        do_start(FIPS_KEY);
        push_fips_keys("ignore");
        track_latency("ignore", 4);
        wait_drain();

        // Out-of-range reads in DONE, then confirm stored keys are intact
        for (int i = 11; i <= 15; i++) push_key("oor_sel", 4'(i), 128'h0, 1'b0);
        push_key("after_oor_r10", 4'd10, FIPS_R10, 1'b0);
        push_key("after_oor_r1",  4'd1,  FIPS_R1,  1'b0);
        wait_drain();

        // Reset at EXPAND cycle 5
        do_start(128'h0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        push_sts("midreset_flags", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i <= 10; i++) push_key("midreset_slot", 4'(i), 128'h0, 1'b1);
        wait_drain();
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // A fresh start after reset completes normally
        do_start(FIPS_KEY);
        push_fips_keys("post_reset");
        track_latency("post_reset", 0);
        wait_drain();

        @(negedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
